shift_result_stage: RTL



---
 rtl/shift_result_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/shift_result_stage.sv
// Registered output stage behind the packed shifter.
// It holds results in a 2-entry FIFO, keeps per-set sticky overflow status and counts delivered results.
module shift_result_stage #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SETS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SETS*WIDTH-1:0]   in_result,
    input  logic [SETS*WIDTH-1:0]   in_overflow,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SETS*WIDTH-1:0]   out_result,
    output logic [SETS-1:0]         out_ovf_flag,
    output logic [SETS-1:0]         sticky_ovf,
    input  logic                    clr_sticky,
    output logic [15:0]             result_count
);

    localparam int unsigned DATA_W  = SETS * WIDTH;
    localparam int unsigned COUNT_W = 16;

    generate
        if (WIDTH < 2 || SETS < 1) begin : g_param_check
            $error("shift_result_stage: WIDTH must be >= 2 and SETS must be >= 1");
        end
    endgenerate

    typedef struct packed {
        logic [SETS-1:0]   flag;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    entry_t            head;
    entry_t            tail;
    entry_t            new_entry;
    logic [SETS-1:0]   push_flag;
    logic              push;
    logic              pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Each set collapses its shifted-out bits into one flag.
    always_comb begin
        push_flag = '0;
        for (int unsigned i = 0; i < SETS; i++) begin
            push_flag[i] = |in_overflow[i*WIDTH +: WIDTH];
        end
    end

    assign new_entry = '{flag: push_flag, data: in_result};

    // FIFO occupancy. Head is zeroed whenever the FIFO drains, so an idle stage reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head      <= '0;
            tail      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head      <= new_entry;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= new_entry;
                    end else if (push) begin
                        tail     <= new_entry;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        head      <= '0;
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head     <= tail;
                        tail     <= '0;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    head      <= '0;
                    tail      <= '0;
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Clear and a same-cycle push combine so the new overflow event survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf <= '0;
        end else if (clr_sticky) begin
            sticky_ovf <= push ? push_flag : SETS'(0);
        end else if (push) begin
            sticky_ovf <= sticky_ovf | push_flag;
        end
    end

    // Delivered-result counter, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_count <= '0;
        end else if (pop && (result_count != {COUNT_W{1'b1}})) begin
            result_count <= result_count + COUNT_W'(1);
        end
    end

    assign out_result   = head.data;
    assign out_ovf_flag = head.flag;

endmodule
